// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : MIPS instruction-fetch sequencer (PC enable, adder stop, mux
//            selects, wrong-path flush). Define FETCH_CTRL_PERF_EN to add
//            saturating stall/flush cycle counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter int BOOT_WAIT = 2,
  parameter int BUBBLES   = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             Zero,
  input  logic             hazard,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             stop,
  output logic             sel_jump,
  output logic             sel_branch,
  output logic             flush,
  output logic             fetch_valid,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] fetch_cnt
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_WAIT);
  localparam logic [1:0] BUB_INIT  = 2'(BUBBLES);

  state_t           state_q, state_d;
  logic [3:0]       boot_q, boot_d;
  logic [1:0]       bub_q, bub_d;
  logic [CNT_W-1:0] fetch_cnt_q;
  logic             redirect;

  assign redirect  = Jump | (Branch & Zero);
  assign state     = state_q;
  assign fetch_cnt = fetch_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_BOOT;
      boot_q      <= BOOT_INIT;
      bub_q       <= 2'd0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      bub_q       <= bub_d;
      fetch_cnt_q <= fetch_cnt_q + CNT_W'(fetch_valid);
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    bub_d       = bub_q;
    pc_we       = 1'b0;
    stop        = 1'b1;
    sel_jump    = 1'b0;
    sel_branch  = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (boot_q != 4'd0) boot_d = boot_q - 4'd1;
        if (boot_q <= 4'd1) state_d = S_RUN;
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (redirect) begin
          // Decode holds the redirect stable, so waiting in RUN is safe.
          if (imem_ready) begin
            pc_we       = 1'b1;
            stop        = 1'b0;
            sel_jump    = Jump;
            sel_branch  = Branch & Zero & ~Jump;
            fetch_valid = 1'b1;
            if (BUBBLES != 0) begin
              state_d = S_FLUSH;
              bub_d   = BUB_INIT;
            end
          end
        end else if (hazard || !imem_ready) begin
          state_d = S_STALL;
        end else begin
          pc_we       = 1'b1;
          stop        = 1'b0;
          fetch_valid = 1'b1;
        end
      end
      S_STALL: begin
        if (halt_req) state_d = S_HALT;
        else if (!hazard && imem_ready) state_d = S_RUN;
      end
      S_FLUSH: begin
        // Decode inputs here come from squashed instructions and are ignored.
        flush = 1'b1;
        if (imem_ready) begin
          pc_we = 1'b1;
          stop  = 1'b0;
          if (bub_q != 2'd0) bub_d = bub_q - 2'd1;
          if (bub_q <= 2'd1) state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (resume) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state_q == S_STALL) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Performance counters absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Scoreboard bench for fetch_ctrl (default build plus a CNT_W=4,
//            BUBBLES=0 instance for counter wrap and zero-bubble redirect).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  // Row layout: {inputs[16:9], outputs[8:3], state[2:0]}
  // inputs  = {rst, Jump, Branch, Zero, hazard, halt_req, resume, imem_ready}
  // outputs = {pc_we, stop, sel_jump, sel_branch, flush, fetch_valid}
  localparam logic [7:0] I_RUN  = 8'b1000_0001;
  localparam logic [7:0] I_NR   = 8'b1000_0000;
  localparam logic [7:0] I_RST  = 8'b0000_0001;
  localparam logic [7:0] I_BR   = 8'b1011_0001;
  localparam logic [7:0] I_BRNT = 8'b1010_0001;
  localparam logic [7:0] I_JB   = 8'b1111_0001;
  localparam logic [7:0] I_J    = 8'b1100_0001;
  localparam logic [7:0] I_JNR  = 8'b1100_0000;
  localparam logic [7:0] I_HAZ  = 8'b1000_1001;
  localparam logic [7:0] I_RES  = 8'b1000_0011;

  localparam logic [5:0] O_IDLE  = 6'b010000;
  localparam logic [5:0] O_FETCH = 6'b100001;
  localparam logic [5:0] O_BR    = 6'b100101;
  localparam logic [5:0] O_JMP   = 6'b101001;
  localparam logic [5:0] O_FLF   = 6'b100010;
  localparam logic [5:0] O_FLW   = 6'b010010;

  localparam logic [2:0] S_BOOT = 3'd0, S_RUN = 3'd1, S_STALL = 3'd2,
                         S_FL = 3'd3, S_HALT = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_w = 1'b0;
  logic Jump = 1'b0, Branch = 1'b0, Zero = 1'b0, hazard = 1'b0;
  logic halt_req = 1'b0, resume = 1'b0, imem_ready = 1'b1;

  logic        pc_we, stop, sel_jump, sel_branch, flush, fetch_valid;
  logic [2:0]  state;
  logic [15:0] fetch_cnt;

  logic        w_pc_we, w_stop, w_sel_jump, w_sel_branch, w_flush, w_fetch_valid;
  logic [2:0]  w_state;
  logic [3:0]  w_fetch_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = '0;
  logic [24:0] sb_q [$];
  logic [9:0]  sbw_q [$];

  fetch_ctrl #(.BOOT_WAIT(2), .BUBBLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .hazard(hazard), .halt_req(halt_req), .resume(resume), .imem_ready(imem_ready),
    .pc_we(pc_we), .stop(stop), .sel_jump(sel_jump), .sel_branch(sel_branch),
    .flush(flush), .fetch_valid(fetch_valid), .state(state), .fetch_cnt(fetch_cnt)
  );

  fetch_ctrl #(.BOOT_WAIT(2), .BUBBLES(0), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst_w), .Jump(Jump), .Branch(Branch), .Zero(Zero),
    .hazard(hazard), .halt_req(halt_req), .resume(resume), .imem_ready(imem_ready),
    .pc_we(w_pc_we), .stop(w_stop), .sel_jump(w_sel_jump), .sel_branch(w_sel_branch),
    .flush(w_flush), .fetch_valid(w_fetch_valid), .state(w_state), .fetch_cnt(w_fetch_cnt)
  );

  always #5 clk = ~clk;

  // Drives one cycle of stimulus and pushes the expected main-DUT outputs.
  task automatic drive_row(input logic [16:0] r);
    @(negedge clk);
    {rst, Jump, Branch, Zero, hazard, halt_req, resume, imem_ready} = r[16:9];
    if (!rst) exp_cnt = '0;
    sb_q.push_back({r[8:0], exp_cnt});
    if (r[3]) exp_cnt = exp_cnt + 16'd1;
    #1;
  endtask

  function automatic logic [24:0] observe();
    return {pc_we, stop, sel_jump, sel_branch, flush, fetch_valid, state, fetch_cnt};
  endfunction

  task automatic test_reset();
    logic [16:0] rows [6];
    logic [24:0] exp, got;
    rows = '{{I_RST, O_IDLE, S_BOOT}, {I_RST, O_IDLE, S_BOOT}, {I_RST, O_IDLE, S_BOOT},
             {I_RUN, O_IDLE, S_BOOT}, {I_RUN, O_IDLE, S_BOOT}, {I_RUN, O_FETCH, S_RUN}};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      exp = sb_q.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_straight();
    logic [24:0] exp, got;
    for (int i = 0; i < 10; i++) begin
      drive_row({I_RUN, O_FETCH, S_RUN});
      exp = sb_q.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL straight[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_branch();
    logic [16:0] rows [12];
    logic [24:0] exp, got;
    rows = '{{I_BR, O_BR, S_RUN}, {I_RUN, O_FLF, S_FL}, {I_RUN, O_FETCH, S_RUN},
             {I_BRNT, O_FETCH, S_RUN}, {I_RUN, O_FETCH, S_RUN},
             {I_JB, O_JMP, S_RUN}, {8'b1111_0101, O_FLF, S_FL}, {I_RUN, O_FETCH, S_RUN},
             {I_J, O_JMP, S_RUN}, {I_NR, O_FLW, S_FL}, {I_RUN, O_FLF, S_FL},
             {I_RUN, O_FETCH, S_RUN}};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      exp = sb_q.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL branch[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall();
    logic [16:0] rows [15];
    logic [24:0] exp, got;
    rows = '{{I_HAZ, O_IDLE, S_RUN}, {I_HAZ, O_IDLE, S_STALL}, {I_HAZ, O_IDLE, S_STALL},
             {I_RUN, O_IDLE, S_STALL}, {I_RUN, O_FETCH, S_RUN},
             {I_JNR, O_IDLE, S_RUN}, {I_JNR, O_IDLE, S_RUN}, {I_J, O_JMP, S_RUN},
             {I_RUN, O_FLF, S_FL}, {I_RUN, O_FETCH, S_RUN},
             {I_NR, O_IDLE, S_RUN}, {I_NR, O_IDLE, S_STALL}, {I_HAZ, O_IDLE, S_STALL},
             {I_RUN, O_IDLE, S_STALL}, {I_RUN, O_FETCH, S_RUN}};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      exp = sb_q.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL stall[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_halt();
    logic [16:0] rows [8];
    logic [24:0] exp, got;
    rows = '{{8'b1100_0111, O_IDLE, S_RUN}, {I_RUN, O_IDLE, S_HALT},
             {I_RES, O_IDLE, S_HALT}, {I_RUN, O_FETCH, S_RUN},
             {I_HAZ, O_IDLE, S_RUN}, {8'b1000_1101, O_IDLE, S_STALL},
             {I_RES, O_IDLE, S_HALT}, {I_RUN, O_FETCH, S_RUN}};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      exp = sb_q.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL halt[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  // Narrow instance: 4-bit counter wraps 15->0, then a jump with no bubbles.
  task automatic test_wrap();
    logic [3:0] wcnt;
    logic [9:0] exp, got;
    wcnt = '0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      {rst, Jump, Branch, Zero, hazard, halt_req, resume, imem_ready} = 8'b0000_0001;
      Jump  = (i == 19);
      rst_w = 1'b1;
      sbw_q.push_back({(i >= 2), (i == 19), 1'b0, ((i < 2) ? S_BOOT : S_RUN), wcnt});
      if (i >= 2) wcnt = wcnt + 4'd1;
      #1;
      exp = sbw_q.pop_front();
      got = {w_pc_we, w_sel_jump, w_flush, w_state, w_fetch_cnt};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, got, exp);
      end
    end
    rst_w   = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_reset_in_flush();
    logic [16:0] rows [8];
    logic [24:0] exp, got;
    rows = '{{I_RUN, O_IDLE, S_BOOT}, {I_RUN, O_IDLE, S_BOOT}, {I_RUN, O_FETCH, S_RUN},
             {I_J, O_JMP, S_RUN}, {I_RST, O_IDLE, S_BOOT},
             {I_RUN, O_IDLE, S_BOOT}, {I_RUN, O_IDLE, S_BOOT}, {I_RUN, O_FETCH, S_RUN}};
    foreach (rows[i]) begin
      drive_row(rows[i]);
      exp = sb_q.pop_front();
      got = observe();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_flush[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_branch();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_in_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
